// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order uop buffer between rename and issue.
// Optional stats counters: define DISPATCH_QUEUE_STATS_EN.

package uop_pkg;
  typedef logic [7:0] uop_tag_t;
  localparam uop_tag_t UOP_NOP      = 8'h00;
  localparam uop_tag_t UOP_INT_ALU  = 8'h01;
  localparam uop_tag_t UOP_INT_MUL  = 8'h02;
  localparam uop_tag_t UOP_LOAD     = 8'h03;
  localparam uop_tag_t UOP_STORE    = 8'h04;
  localparam uop_tag_t UOP_BRANCH   = 8'h05;
  localparam uop_tag_t UOP_CAP_JUMP = 8'h40;
  localparam uop_tag_t UOP_CAP_LOAD = 8'h41;
endpackage

module dispatch_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rename_valid_i,
  input  uop_tag_t                 rename_uop0_i,
  input  uop_tag_t                 rename_uop1_i,
  input  logic [1:0]               rename_uop_count_i,
  input  logic [1:0]               rename_is_cap_i,
  output logic                     dispatch_ready_o,
  output logic                     issue_valid_o,
  output uop_tag_t                 issue_uop_o,
  output logic                     issue_is_cap_o,
  input  logic                     issue_ready_i,
  input  logic                     cap_done_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     cap_wait_o,
  output logic [CNT_W-1:0]         cap_wait_cycles_o,
  output logic [CNT_W-1:0]         issued_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    CAP_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     wptr1;
  logic [OCC_W-1:0]     occ_q, occ_d;
  uop_tag_t             tag_q [DEPTH];
  logic [DEPTH-1:0]     cap_q;
  logic [1:0]           n_push;
  logic [1:0]           n_eff;
  logic                 push_fire;
  logic                 issue_fire;
  logic                 empty;

  // lanes requested; count 3 behaves like 2
  always_comb begin
    n_push = 2'd0;
    unique case (rename_uop_count_i)
      2'd0:    n_push = 2'd0;
      2'd1:    n_push = 2'd1;
      default: n_push = 2'd2;
    endcase
  end

  // ready looks only at registered occupancy, never at a same-cycle pop
  assign dispatch_ready_o = occ_q <= OCC_W'(DEPTH - 2);
  assign empty            = occ_q == '0;
  assign issue_valid_o    = !empty && (state_q == IDLE);
  assign issue_uop_o      = empty ? '0 : tag_q[rptr_q];
  assign issue_is_cap_o   = !empty && cap_q[rptr_q];
  assign push_fire        = rename_valid_i && dispatch_ready_o;
  assign issue_fire       = issue_valid_o && issue_ready_i;
  assign n_eff            = push_fire ? n_push : 2'd0;
  assign wptr1            = wptr_q + 1'b1;
  assign occupancy_o      = occ_q;
  assign cap_wait_o       = state_q == CAP_WAIT;

  // pointer and occupancy next state; flush wins over push/pop
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      occ_d  = '0;
    end else begin
      wptr_d = wptr_q + PTR_W'(n_eff);
      if (issue_fire) rptr_d = rptr_q + 1'b1;
      occ_d = occ_q + OCC_W'(n_eff)
            - OCC_W'(issue_fire);
    end
  end

  // FSM next state: a cap issue blocks until cap_done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (issue_fire && issue_is_cap_o)
          state_d = CAP_WAIT;
      CAP_WAIT:
        if (cap_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      occ_q   <= occ_d;
    end
  end

  // entry storage: lane 0 then lane 1 at consecutive slots
  always_ff @(posedge clk_i) begin
    if (push_fire && !flush_i) begin
      if (n_push != 2'd0) begin
        tag_q[wptr_q] <= rename_uop0_i;
        cap_q[wptr_q] <= rename_is_cap_i[0];
      end
      if (n_push == 2'd2) begin
        tag_q[wptr1] <= rename_uop1_i;
        cap_q[wptr1] <= rename_is_cap_i[1];
      end
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [CNT_W-1:0] cwc_q, cwc_d;
  logic [CNT_W-1:0] ic_q, ic_d;

  // saturating stall and issue counters, untouched by flush
  always_comb begin
    cwc_d = cwc_q;
    ic_d  = ic_q;
    if ((state_q == CAP_WAIT) && !empty && !(&cwc_q))
      cwc_d = cwc_q + 1'b1;
    if (issue_fire && !(&ic_q))
      ic_d = ic_q + 1'b1;
  end

  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cwc_q <= '0;
      ic_q  <= '0;
    end else begin
      cwc_q <= cwc_d;
      ic_q  <= ic_d;
    end
  end

  assign cap_wait_cycles_o = cwc_q;
  assign issued_count_o    = ic_q;
`else
  assign cap_wait_cycles_o = '0;
  assign issued_count_o    = '0;
`endif

  // occupancy can never exceed the buffer size
  a_occ_bound : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    occ_q <= OCC_W'(DEPTH)
  );

endmodule
